twp_master: RTL

- Two-Wire Protocol (TWP) host-side master. It sits directly upstream of the TPA slave and produces the SCL/SDA frames the slave consumes.
- It accepts one register command at a time on a valid/ready interface, serialises it onto SDA, and returns write completion or read data on a one-cycle response strobe.
- It lets system logic (test host or bridge) reach the 256x16 register space through the two-wire port.

---
 rtl/twp_master_if.sv | 45 ++++
 rtl/twp_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/twp_master_if.sv
// rtl/twp_master_if.sv - command/response handshake bundle for the two-wire protocol master
//
// Purpose: groups the command request and the response strobe of twp_master.
// Signals:
//   cmd_valid  requester has a command
//   cmd_ready  master can accept a command
//   cmd_write  1=write, 0=read
//   cmd_addr   register address
//   cmd_wdata  write data
//   rsp_valid  one-cycle pulse, frame finished
//   rsp_rdata  read data (0 for writes, 16'hFFFF on read timeout)
//   rsp_err    read timed out, meaningful only with rsp_valid
// Modports: master (the twp_master side), slave (the requester side).
interface twp_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    output cmd_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );

  modport slave (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );
endinterface

// File: rtl/twp_master.sv
// rtl/twp_master.sv - two-wire protocol host-side master serialising register commands onto SCL/SDA
//
// Purpose: accepts one register command at a time, sends START, CMD, 8 address bits
// (LSB first) and, for writes, 16 data bits (LSB first). For reads it releases SDA,
// waits for the slave's start bit (SDA=0) and samples 16 data bits. A one-cycle
// rsp_valid strobe closes every frame, followed by IDLE_GAP released-bus cycles.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    twp_master_if.master: cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata,
//          rsp_valid/rsp_rdata/rsp_err
//   SCL    frame-active strobe, high from START through the last data bit
//   SDA    bidirectional data line, driven 0/1 or released (z); pulled up on the board
// Parameters: RD_TIMEOUT (4..255), IDLE_GAP (1..15).
// Optional feature: macro TWP_RD_TIMEOUT_EN enables the read-start timeout and rsp_err.
// Without it TURN waits indefinitely for the start bit and rsp_err is tied 0.
module twp_master #(
  parameter int RD_TIMEOUT = 16,
  parameter int IDLE_GAP   = 2
) (
  input  logic              clk,
  input  logic              reset,
  twp_master_if.master      bus,
  output logic              SCL,
  inout  wire               SDA
);

  // Elaboration-time parameter range guards.
  if (RD_TIMEOUT < 4 || RD_TIMEOUT > 255) begin : g_bad_rd_timeout
    $error("twp_master: RD_TIMEOUT out of range 4..255");
  end
  if (IDLE_GAP < 1 || IDLE_GAP > 15) begin : g_bad_idle_gap
    $error("twp_master: IDLE_GAP out of range 1..15");
  end

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_TURN,
    ST_RDATA,
    ST_RESP,
    ST_GAP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_write;
  logic [7:0]  r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata_sh;

  logic [3:0]  r_bit_cnt;
  logic [3:0]  w_bit_cnt_next;
  logic [3:0]  r_gap_cnt;
  logic [3:0]  w_gap_cnt_next;

  logic        r_sda_oe;
  logic        r_sda_out;
  logic        r_scl;
  logic        w_sda_oe;
  logic        w_sda_out;
  logic        w_scl;

  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;

  logic        w_sda_low;
  logic [15:0] w_rdata_shift;
  logic        w_to_expired;

`ifdef TWP_RD_TIMEOUT_EN
  logic [7:0]  r_to_cnt;
  logic [7:0]  w_to_cnt_next;
  logic        r_rsp_err;
`endif

  // Only a clean 0 is a start bit; a released (z) or unknown line must not match.
  assign w_sda_low     = (SDA == 1'b0);
  // Read data arrives LSB first, so shift in from the top.
  assign w_rdata_shift = {SDA, r_rdata_sh[15:1]};

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_gap_cnt_next = r_gap_cnt;
    w_to_expired   = 1'b0;
`ifdef TWP_RD_TIMEOUT_EN
    w_to_cnt_next  = r_to_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        w_state_next = ST_CMD;
      end
      ST_CMD: begin
        w_state_next   = ST_ADDR;
        w_bit_cnt_next = 4'd0;
      end
      ST_ADDR: begin
        if (r_bit_cnt == 4'd7) begin
          w_bit_cnt_next = 4'd0;
          w_state_next   = r_write ? ST_WDATA : ST_TURN;
`ifdef TWP_RD_TIMEOUT_EN
          // First TURN cycle counts as 1.
          w_to_cnt_next  = 8'd1;
`endif
        end else begin
          w_bit_cnt_next = r_bit_cnt + 4'd1;
        end
      end
      ST_WDATA: begin
        if (r_bit_cnt == 4'd15) begin
          w_bit_cnt_next = 4'd0;
          w_state_next   = ST_RESP;
        end else begin
          w_bit_cnt_next = r_bit_cnt + 4'd1;
        end
      end
      ST_TURN: begin
        if (w_sda_low) begin
          w_bit_cnt_next = 4'd0;
          w_state_next   = ST_RDATA;
`ifdef TWP_RD_TIMEOUT_EN
          w_to_cnt_next  = 8'd0;
        end else if (r_to_cnt == RD_TIMEOUT[7:0]) begin
          w_to_cnt_next  = 8'd0;
          w_to_expired   = 1'b1;
          w_state_next   = ST_RESP;
        end else begin
          w_to_cnt_next  = r_to_cnt + 8'd1;
`endif
        end
      end
      ST_RDATA: begin
        if (r_bit_cnt == 4'd15) begin
          w_bit_cnt_next = 4'd0;
          w_state_next   = ST_RESP;
        end else begin
          w_bit_cnt_next = r_bit_cnt + 4'd1;
        end
      end
      ST_RESP: begin
        w_state_next   = ST_GAP;
        w_gap_cnt_next = 4'd1;
      end
      ST_GAP: begin
        if (r_gap_cnt == IDLE_GAP[3:0]) begin
          w_gap_cnt_next = 4'd0;
          w_state_next   = ST_IDLE;
        end else begin
          w_gap_cnt_next = r_gap_cnt + 4'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Line values are decoded from the next state so the registered SCL/SDA
    // line up with the state they belong to.
    w_sda_oe  = 1'b0;
    w_sda_out = 1'b0;
    w_scl     = 1'b0;
    case (w_state_next)
      ST_START: begin
        w_sda_oe  = 1'b1;
        w_sda_out = 1'b0;
        w_scl     = 1'b1;
      end
      ST_CMD: begin
        w_sda_oe  = 1'b1;
        w_sda_out = r_write;
        w_scl     = 1'b1;
      end
      ST_ADDR: begin
        w_sda_oe  = 1'b1;
        w_sda_out = r_addr[w_bit_cnt_next[2:0]];
        w_scl     = 1'b1;
      end
      ST_WDATA: begin
        w_sda_oe  = 1'b1;
        w_sda_out = r_wdata[w_bit_cnt_next];
        w_scl     = 1'b1;
      end
      ST_TURN, ST_RDATA: begin
        w_scl     = 1'b1;
      end
      default: begin
        w_scl     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 16'h0000;
      r_rdata_sh  <= 16'h0000;
      r_bit_cnt   <= 4'd0;
      r_gap_cnt   <= 4'd0;
      r_sda_oe    <= 1'b0;
      r_sda_out   <= 1'b0;
      r_scl       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 16'h0000;
`ifdef TWP_RD_TIMEOUT_EN
      r_to_cnt    <= 8'd0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_gap_cnt   <= w_gap_cnt_next;
      r_sda_oe    <= w_sda_oe;
      r_sda_out   <= w_sda_out;
      r_scl       <= w_scl;
      r_rsp_valid <= (w_state_next == ST_RESP);
`ifdef TWP_RD_TIMEOUT_EN
      r_to_cnt    <= w_to_cnt_next;
`endif

      // Command fields are frozen at acceptance; later bus changes are ignored.
      if (r_state == ST_IDLE && bus.cmd_valid) begin
        r_write <= bus.cmd_write;
        r_addr  <= bus.cmd_addr;
        r_wdata <= bus.cmd_wdata;
      end

      if (r_state == ST_RDATA) begin
        r_rdata_sh <= w_rdata_shift;
      end

      // Response fields only change on entry to RESP and hold until the next one.
      if (w_state_next == ST_RESP) begin
        if (r_state == ST_RDATA) begin
          r_rsp_rdata <= w_rdata_shift;
        end else if (w_to_expired) begin
          r_rsp_rdata <= 16'hFFFF;
        end else begin
          r_rsp_rdata <= 16'h0000;
        end
`ifdef TWP_RD_TIMEOUT_EN
        r_rsp_err   <= w_to_expired;
`endif
      end
    end
  end

  assign SDA           = r_sda_oe ? r_sda_out : 1'bz;
  assign SCL           = r_scl;
  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
`ifdef TWP_RD_TIMEOUT_EN
  assign bus.rsp_err   = r_rsp_err;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule
